counter_event_fifo: RTL and testbench
=====================================

Name: counter_event_fifo

Overview:
- Downstream consumer of the up-counter's count output.
- Watches the count value every cycle and detects two events: wrap-around and threshold match.
- Each event is timestamped and stored in a small FIFO, drained by a valid/ready interface.
- Also keeps a saturating wrap counter and a sticky overflow flag for dropped events.

Parameters:
- WIDTH, 6, width of count_in, thresh and evt_count (matches the counter output width).
- MAX_COUNT, 20, terminal value of the upstream counter; used only by the bench and assertions (count_in <= MAX_COUNT).
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- TS_WIDTH, 16, width of the free-running timestamp.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- count_in  input  WIDTH  count value from the upstream counter; changes synchronously to clk.
- thresh  input  WIDTH  match threshold; quasi-static, sampled every cycle.
- evt_ready  input  1  consumer accepts the head entry when high with evt_valid.
- clr_ovf  input  1  single-cycle clear of overflow.
- evt_valid  output  1  FIFO non-empty; head entry present on evt_*.
- evt_type  output  2  01 = wrap, 10 = match, 11 = wrap and match in the same cycle; 00 never presented while valid.
- evt_count  output  WIDTH  count_in value at the event cycle.
- evt_time  output  TS_WIDTH  timestamp at the event cycle.
- wrap_cnt  output  8  total wrap events detected (including dropped), saturates at 255.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO flushed; rd/wr pointers and occupancy = 0.
  - evt_valid = 0; evt_type, evt_count, evt_time = 0.
  - wrap_cnt = 0, overflow = 0, timestamp = 0.
  - prev_count = 0, primed = 0.
  - A reset mid-operation discards all stored entries.
- Timestamp:
  - Increments by 1 every cycle out of reset.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Priming and previous value:
  - First cycle after reset release: prev_count <= count_in, primed <= 1, no event detected.
  - prev_count updates every cycle thereafter.
- Wrap detect: primed && (count_in < prev_count). Any decrease counts as a wrap, not only MAX_COUNT -> 0.
- Match detect: primed && (count_in == thresh) && (count_in != prev_count). This is edge-qualified: a counter stalled at thresh produces one event only.
- Event entry: if wrap or match, one entry {type, count_in, timestamp} is formed in that cycle. Both conditions together give a single entry with type 11.
- FIFO push:
  - Push if an event occurs and the FIFO is not full.
  - Also push when full if a pop happens in the same cycle; push and pop then both execute and occupancy is unchanged.
- FIFO pop: occurs when evt_valid && evt_ready.
- Output timing:
  - Show-ahead FIFO: the head entry is driven on evt_* whenever evt_valid = 1.
  - Event at cycle N gives evt_valid = 1 from cycle N+1 if the FIFO was empty (1-cycle latency).
  - Push into an empty FIFO with no pending pop is never bypassed combinationally.
- Handshake rules:
  - evt_* are stable while evt_valid && !evt_ready.
  - evt_ready while !evt_valid has no effect.
- Overflow:
  - Event while full and no pop: the entry is dropped and overflow <= 1.
  - clr_ovf = 1 clears overflow.
  - Set and clear in the same cycle: set wins.
- wrap_cnt:
  - +1 on every detected wrap, whether pushed or dropped.
  - Holds at 255.

Test Plan:
- Basic wrap: counter runs 0..20, thresh = 63 (no match), evt_ready = 1, across the 20 -> 0 transition -> one entry {01, 0, t}; evt_valid high 1 cycle after count_in = 0; wrap_cnt = 1.
- Match: thresh = 10, counter 0..20 twice -> two type-10 entries, evt_count = 10; timestamps differ by 21; plus two wraps -> 4 entries total in order.
- Coincident events: thresh = 0, wrap 20 -> 0 -> single entry with type 11 and evt_count = 0; wrap_cnt increments.
- Backpressure/overflow: evt_ready = 0, DEPTH = 4, generate 6 events -> 4 stored and overflow = 1. Raise evt_ready -> entries drain oldest-first and values are stable while stalled. Pulse clr_ovf -> overflow = 0.
- Full with simultaneous push/pop: FIFO full, event coincides with evt_ready = 1 -> occupancy stays 4, no overflow, new entry appears last.
- Reset mid-operation: 3 entries queued, assert reset low for 2 cycles -> evt_valid = 0, wrap_cnt = 0, timestamp = 0. After release, the first cycle creates no event even if count_in = 0 while prev_count = 0.

Source files
------------

// File: rtl/counter_event_fifo.sv
//==============================================================================
// Module      : counter_event_fifo
// Description : Watches an up-counter's count value and records wrap-around
//               and threshold-match events into a small show-ahead FIFO. Each
//               entry holds the event type, the count value and a free-running
//               timestamp. It also keeps a saturating wrap counter and a sticky
//               overflow flag for events dropped on a full FIFO.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-low reset
//               count_in   - count value from the upstream counter
//               thresh     - match threshold (quasi-static)
//               evt_ready  - consumer accepts head entry when evt_valid
//               clr_ovf    - single-cycle clear of overflow
//               evt_valid  - FIFO non-empty, head entry on evt_*
//               evt_type   - 01 wrap, 10 match, 11 both
//               evt_count  - count_in at the event cycle
//               evt_time   - timestamp at the event cycle
//               wrap_cnt   - saturating count of detected wraps
//               overflow   - sticky dropped-event flag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_event_fifo #(
    parameter int WIDTH     = 6,
    parameter int MAX_COUNT = 20,
    parameter int DEPTH     = 4,
    parameter int TS_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    count_in,
    input  logic [WIDTH-1:0]    thresh,
    input  logic                evt_ready,
    input  logic                clr_ovf,
    output logic                evt_valid,
    output logic [1:0]          evt_type,
    output logic [WIDTH-1:0]    evt_count,
    output logic [TS_WIDTH-1:0] evt_time,
    output logic [7:0]          wrap_cnt,
    output logic                overflow
);

    localparam int                c_AW    = $clog2(DEPTH);
    localparam int                c_EW    = 2 + WIDTH + TS_WIDTH;
    localparam logic [c_AW:0]     c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0]  c_MAX   = WIDTH'(MAX_COUNT);

    logic [TS_WIDTH-1:0] r_ts;
    logic [WIDTH-1:0]    r_prev;
    logic                r_primed;
    logic [c_EW-1:0]     r_mem [DEPTH];
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW:0]       r_occ;
    logic [7:0]          r_wrap_cnt;
    logic                r_ovf;

    logic                w_wrap;
    logic                w_match;
    logic                w_evt;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_EW-1:0]     w_entry;
    logic [c_EW-1:0]     w_head;

    // Any decrease is a wrap; a match needs the count to have just arrived at
    // the threshold so a stalled counter yields a single event.
    assign w_wrap  = r_primed && (count_in < r_prev);
    assign w_match = r_primed && (count_in == thresh) && (count_in != r_prev);
    assign w_evt   = w_wrap || w_match;
    assign w_entry = {w_match, w_wrap, count_in, r_ts};

    assign w_full  = (r_occ == c_FULL);
    assign w_pop   = (r_occ != '0) && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_evt && (!w_full || w_pop);
    assign w_drop  = w_evt && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts     <= '0;
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_prev   <= count_in;
            r_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
                r_wrap_cnt <= r_wrap_cnt + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        evt_valid = (r_occ != '0);
        {evt_type, evt_count, evt_time} = '0;
        if (evt_valid) begin
            {evt_type, evt_count, evt_time} = w_head;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
    assign overflow = r_ovf;

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        count_in <= c_MAX);

endmodule

`default_nettype wire

// File: tb/tb_counter_event_fifo.sv
//==============================================================================
// Module      : tb_counter_event_fifo
// Description : Self-checking bench for counter_event_fifo: hand-written
//               vector table, directed corner sequences and a randomized run
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_event_fifo;

    localparam int WIDTH     = 6;
    localparam int MAX_COUNT = 20;
    localparam int DEPTH     = 4;
    localparam int TS_WIDTH  = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [WIDTH-1:0]    count_in;
    logic [WIDTH-1:0]    thresh;
    logic                evt_ready;
    logic                clr_ovf;
    logic                evt_valid;
    logic [1:0]          evt_type;
    logic [WIDTH-1:0]    evt_count;
    logic [TS_WIDTH-1:0] evt_time;
    logic [7:0]          wrap_cnt;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    counter_event_fifo #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .DEPTH     (DEPTH),
        .TS_WIDTH  (TS_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .thresh    (thresh),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_type  (evt_type),
        .evt_count (evt_count),
        .evt_time  (evt_time),
        .wrap_cnt  (wrap_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]          t;
        logic [WIDTH-1:0]    c;
        logic [TS_WIDTH-1:0] ts;
    } ent_t;

    ent_t                m_q[$];
    logic [TS_WIDTH-1:0] m_ts;
    logic [WIDTH-1:0]    m_prev;
    logic                m_primed;
    int                  m_wc;
    logic                m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_ts = '0; m_prev = '0; m_primed = 1'b0; m_wc = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] th,
                              input logic rdy, input logic clr);
        logic wrap, match, drop;
        ent_t e;
        wrap  = m_primed && (cnt < m_prev);
        match = m_primed && (cnt == th) && (cnt != m_prev);
        drop  = 1'b0;
        if (rdy && m_q.size() > 0) m_q.delete(0);
        if (wrap || match) begin
            e.t = {match, wrap}; e.c = cnt; e.ts = m_ts;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (wrap && m_wc < 255) m_wc++;
        m_ts     = m_ts + 1'b1;
        m_prev   = cnt;
        m_primed = 1'b1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_v;
        exp_v = (m_q.size() > 0);
        chk("evt_valid", 32'(evt_valid), 32'(exp_v));
        if (exp_v) begin
            chk("evt_type", 32'(evt_type), 32'(m_q[0].t));
            chk("evt_count", 32'(evt_count), 32'(m_q[0].c));
            chk("evt_time", 32'(evt_time), 32'(m_q[0].ts));
        end else begin
            chk("evt_type_idle", 32'(evt_type), 32'd0);
            chk("evt_count_idle", 32'(evt_count), 32'd0);
            chk("evt_time_idle", 32'(evt_time), 32'd0);
        end
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wc));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle's inputs, advance model and DUT, then compare.
    task automatic apply(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] th,
                         input logic rdy, input logic clr);
        count_in = cnt; thresh = th; evt_ready = rdy; clr_ovf = clr;
        model_step(cnt, th, rdy, clr);
        @(posedge clk); #1;
        compare_model();
    endtask

    // Called #1 after a rising edge; leaves reset released #1 after an edge.
    task automatic do_reset();
        reset = 1'b0;
        count_in = '0; thresh = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        compare_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [WIDTH-1:0]    cnt;
        logic [WIDTH-1:0]    th;
        logic                rdy;
        logic                clr;
        logic                v;
        logic [1:0]          t;
        logic [WIDTH-1:0]    c;
        logic [TS_WIDTH-1:0] ts;
        logic [7:0]          wc;
        logic                ovf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;
        int pr;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] th;

        reset = 1'b0; count_in = '0; thresh = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Row k runs with timestamp k (first cycle after release is priming).
        tbl[0]  = '{6'd18, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd0, 1'b0};
        tbl[1]  = '{6'd19, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd0, 1'b0};
        tbl[2]  = '{6'd20, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd0, 1'b0};
        tbl[3]  = '{6'd0,  6'd0, 1'b0, 1'b0, 1'b1, 2'd3, 6'd0, 16'd3,  8'd1, 1'b0};
        tbl[4]  = '{6'd1,  6'd0, 1'b0, 1'b0, 1'b1, 2'd3, 6'd0, 16'd3,  8'd1, 1'b0};
        tbl[5]  = '{6'd1,  6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd1, 1'b0};
        tbl[6]  = '{6'd5,  6'd5, 1'b0, 1'b0, 1'b1, 2'd2, 6'd5, 16'd6,  8'd1, 1'b0};
        tbl[7]  = '{6'd5,  6'd5, 1'b0, 1'b0, 1'b1, 2'd2, 6'd5, 16'd6,  8'd1, 1'b0};
        tbl[8]  = '{6'd3,  6'd5, 1'b0, 1'b0, 1'b1, 2'd2, 6'd5, 16'd6,  8'd2, 1'b0};
        tbl[9]  = '{6'd4,  6'd5, 1'b1, 1'b0, 1'b1, 2'd1, 6'd3, 16'd8,  8'd2, 1'b0};
        tbl[10] = '{6'd5,  6'd5, 1'b1, 1'b0, 1'b1, 2'd2, 6'd5, 16'd10, 8'd2, 1'b0};
        tbl[11] = '{6'd6,  6'd5, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd2, 1'b0};
        tbl[12] = '{6'd7,  6'd5, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 16'd0,  8'd2, 1'b0};

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].cnt, tbl[i].th, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_type", i), 32'(evt_type), 32'(tbl[i].t));
            chk($sformatf("tbl%0d_count", i), 32'(evt_count), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_time", i), 32'(evt_time), 32'(tbl[i].ts));
            chk($sformatf("tbl%0d_wrap_cnt", i), 32'(wrap_cnt), 32'(tbl[i].wc));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
        end

        // Backpressure: six wraps into a 4-deep FIFO with no consumer.
        for (int k = 6; k >= 1; k--) apply(6'(k), 6'd63, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_wrap_cnt", 32'(wrap_cnt), 32'd8);
        chk("ovf_head_count", 32'(evt_count), 32'd6);
        apply(6'd1, 6'd63, 1'b0, 1'b0);
        chk("stall_head_count", 32'(evt_count), 32'd6);
        // Drop and clear together: the drop wins.
        apply(6'd0, 6'd63, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(overflow), 32'd1);
        apply(6'd0, 6'd63, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        // Full FIFO, match coincides with a pop: accepted, no overflow.
        apply(6'd20, 6'd20, 1'b1, 1'b0);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        chk("full_pushpop_head", 32'(evt_count), 32'd5);
        n = 0;
        while (evt_valid && n < 10) begin
            apply(6'd20, 6'd20, 1'b1, 1'b0);
            n++;
        end
        chk("drained_entries", 32'(n), 32'd4);

        // Reset with three entries queued.
        for (int k = 10; k >= 8; k--) apply(6'(k), 6'd63, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(evt_valid), 32'd1);
        do_reset();
        apply(6'd0, 6'd0, 1'b0, 1'b0);
        chk("post_reset_prime", 32'(evt_valid), 32'd0);
        apply(6'd0, 6'd0, 1'b0, 1'b0);
        chk("post_reset_stall", 32'(evt_valid), 32'd0);
        apply(6'd1, 6'd1, 1'b0, 1'b0);
        chk("post_reset_type", 32'(evt_type), 32'd2);
        chk("post_reset_time", 32'(evt_time), 32'd2);

        // Randomized run against the model.
        c  = 6'd1;
        th = 6'd10;
        pr = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            if (cyc % 250 == 0) begin
                case ($urandom % 3)
                    0:       pr = 10;
                    1:       pr = 50;
                    default: pr = 90;
                endcase
            end
            if (cyc % 97 == 0) th = 6'($urandom_range(0, MAX_COUNT));
            if (cyc == 1500) do_reset();
            r = int'($urandom % 16);
            if (r < 10)      c = (c == 6'(MAX_COUNT)) ? 6'd0 : c + 6'd1;
            else if (r < 14) c = c;
            else             c = 6'($urandom_range(0, MAX_COUNT));
            apply(c, th, ($urandom % 100) < pr, ($urandom % 20) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
